// File: rtl/order_manager_pkg.sv
// Shared order-word layout and stock-table constants for the order manager slice.
package order_manager_pkg;

    localparam int N_STOCKS  = 4;
    localparam int STOCK_W   = 2;
    localparam int QTY_W     = 7;
    localparam int PRICE_W   = 14;
    localparam int ORD_W     = 24;
    localparam int POS_W     = QTY_W;

    localparam int SIDE_BIT  = 23;
    localparam int STOCK_LSB = 21;
    localparam int QTY_LSB   = 14;
    localparam int PRICE_LSB = 0;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    function automatic logic [ORD_W-1:0] pack_order(
        input logic               side,
        input logic [STOCK_W-1:0] stk,
        input logic [QTY_W-1:0]   qty,
        input logic [PRICE_W-1:0] prc
    );
        logic [ORD_W-1:0] w_word;
        w_word = '0;
        w_word[SIDE_BIT]                   = side;
        w_word[STOCK_LSB +: STOCK_W]       = stk;
        w_word[QTY_LSB +: QTY_W]           = qty;
        w_word[PRICE_LSB +: PRICE_W]       = prc;
        return w_word;
    endfunction

endpackage

// File: rtl/order_manager_if.sv
// Valid/ready order stream leaving the order manager; master is the producer.
interface order_manager_if;
    import order_manager_pkg::*;

    logic             order_valid;
    logic             order_ready;
    logic [ORD_W-1:0] order_data;

    modport master (output order_valid, output order_data, input order_ready);
    modport slave  (input order_valid, input order_data, output order_ready);

endinterface

// File: rtl/order_manager_fifo.sv
// Power-of-two order queue; read side is valid/ready, full judged on current count.
module order_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign rd_valid = (r_count != '0);
    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign w_push   = wr_en && !full;
    assign w_pop    = rd_valid && rd_ready;

    // Storage is left uninitialised on reset; the cleared count hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/order_manager.sv
// Turns momentum buy/sell signals into queued orders while tracking per-stock lots.
module order_manager
    import order_manager_pkg::*;
#(
    parameter int MAX_POS    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      buy_signal,
    input  logic                      sell_signal,
    input  logic [STOCK_W-1:0]        stock_id,
    input  logic [PRICE_W-1:0]        price,
    order_manager_if.master           ord,
    output logic [4:0]                fifo_count,
    output logic [7:0]                drop_count,
    output logic [N_STOCKS*POS_W-1:0] position
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [POS_W-1:0] r_pos [N_STOCKS];
    logic [7:0]       r_drop;
    logic [POS_W-1:0] w_pos_cur;
    logic             w_req_buy;
    logic             w_req_sell;
    logic             w_req_both;
    logic             w_buy_ok;
    logic             w_sell_ok;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [ORD_W-1:0] w_wr_data;

    assign w_pos_cur  = r_pos[stock_id];
    assign w_req_buy  = enable &&  buy_signal && !sell_signal;
    assign w_req_sell = enable && !buy_signal &&  sell_signal;
    assign w_req_both = enable &&  buy_signal &&  sell_signal;

    // Accept decisions use start-of-cycle position and queue occupancy only.
    assign w_buy_ok  = w_req_buy  && (w_pos_cur < POS_W'(MAX_POS)) && !w_full;
    assign w_sell_ok = w_req_sell && (w_pos_cur != '0) && !w_full;
    assign w_push    = w_buy_ok || w_sell_ok;
    assign w_drop    = w_req_both || (w_req_buy && !w_buy_ok) || (w_req_sell && !w_sell_ok);

    assign w_wr_data = pack_order(w_buy_ok ? SIDE_BUY : SIDE_SELL, stock_id,
                                  w_buy_ok ? QTY_W'(1) : w_pos_cur, price);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_STOCKS; i++) r_pos[i] <= '0;
            r_drop <= '0;
        end else begin
            if (w_buy_ok)       r_pos[stock_id] <= w_pos_cur + POS_W'(1);
            else if (w_sell_ok) r_pos[stock_id] <= '0;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    always_comb begin
        position = '0;
        for (int i = 0; i < N_STOCKS; i++) position[POS_W*i +: POS_W] = r_pos[i];
    end

    assign drop_count = r_drop;
    assign fifo_count = 5'(w_count);

    order_fifo #(
        .WIDTH (ORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_push),
        .wr_data  (w_wr_data),
        .rd_valid (ord.order_valid),
        .rd_ready (ord.order_ready),
        .rd_data  (ord.order_data),
        .full     (w_full),
        .count    (w_count)
    );

endmodule

// File: tb/tb_order_manager.sv
// Directed checks of order_manager (default build plus a MAX_POS=2 build).
module tb_order_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        buy = 1'b0;
    logic        sell = 1'b0;
    logic        ready = 1'b0;
    logic [1:0]  stk = '0;
    logic [13:0] price = '0;

    logic [4:0]  cnt1, cnt2;
    logic [7:0]  drop1, drop2;
    logic [27:0] pos1, pos2;

    int n_chk = 0;
    int n_fail = 0;

    order_manager_if u_if1 ();
    order_manager_if u_if2 ();
    assign u_if1.order_ready = ready;
    assign u_if2.order_ready = ready;

    always #5 clk = ~clk;

    order_manager u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .buy_signal(buy), .sell_signal(sell),
        .stock_id(stk), .price(price), .ord(u_if1),
        .fifo_count(cnt1), .drop_count(drop1), .position(pos1)
    );

    order_manager #(.MAX_POS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .buy_signal(buy), .sell_signal(sell),
        .stock_id(stk), .price(price), .ord(u_if2),
        .fifo_count(cnt2), .drop_count(drop2), .position(pos2)
    );

    function automatic logic [27:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
    endfunction

    function automatic logic [23:0] ordw(input logic side, input int s, input int q, input int p);
        return {side, 2'(s), 7'(q), 14'(p)};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic b, input logic s, input int id, input int pr);
        enable = en;
        buy    = b;
        sell   = s;
        stk    = 2'(id);
        price  = 14'(pr);
    endtask

    initial begin
        #12;
        chk_eq("rst_valid", u_if1.order_valid, 0);
        chk_eq("rst_count", cnt1, 0);
        chk_eq("rst_drop",  drop1, 0);
        chk_eq("rst_pos",   pos1, 0);
        rst = 1'b1;

        // first buy after reset
        drive(1, 1, 0, 2, 1000);
        step;
        drive(0, 0, 0, 0, 0);
        chk_eq("t1_valid", u_if1.order_valid, 1);
        chk_eq("t1_data",  u_if1.order_data, ordw(1, 2, 1, 1000));
        chk_eq("t1_pos",   pos1, pk(0, 0, 1, 0));
        chk_eq("t1_count", cnt1, 1);
        ready = 1'b1;
        step;
        chk_eq("t1_drain", cnt1, 0);
        chk_eq("t1_nvalid", u_if1.order_valid, 0);

        // three buys on stock 1 with continuous drain, then sell all
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 500 + i);
            step;
            chk_eq("t2_cnt_buy", cnt1, 1);
        end
        chk_eq("t2_pos3", pos1, pk(0, 3, 1, 0));
        drive(1, 0, 1, 1, 1500);
        step;
        drive(0, 0, 0, 0, 0);
        chk_eq("t2_sell_data", u_if1.order_data, ordw(0, 1, 3, 1500));
        chk_eq("t2_sell_pos",  pos1, pk(0, 0, 1, 0));
        chk_eq("t2_count",     cnt1, 1);
        step;
        chk_eq("t2_drain", cnt1, 0);

        // fill the queue with ready low; fifth buy is dropped
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, i % 4, 100 + i);
            step;
        end
        drive(0, 0, 0, 0, 0);
        chk_eq("t3_count", cnt1, 4);
        chk_eq("t3_drop",  drop1, 1);
        chk_eq("t3_pos",   pos1, pk(1, 1, 2, 1));
        chk_eq("t3_head",  u_if1.order_data, ordw(1, 0, 1, 100));
        step;
        chk_eq("t3_stable", u_if1.order_data, ordw(1, 0, 1, 100));

        // full queue with a dequeue in the same cycle still blocks the buy
        ready = 1'b1;
        drive(1, 1, 0, 1, 200);
        step;
        drive(0, 0, 0, 0, 0);
        chk_eq("t3_full_count", cnt1, 3);
        chk_eq("t3_full_drop",  drop1, 2);
        chk_eq("t3_full_pos",   pos1, pk(1, 1, 2, 1));
        chk_eq("t3_head1",      u_if1.order_data, ordw(1, 1, 1, 101));
        step;
        chk_eq("t3_head2",      u_if1.order_data, ordw(1, 2, 1, 102));
        chk_eq("t3_count2",     cnt1, 2);
        ready = 1'b0;

        // asynchronous reset mid-cycle with two orders queued
        #3;
        rst = 1'b0;
        #1;
        chk_eq("ar_valid", u_if1.order_valid, 0);
        chk_eq("ar_count", cnt1, 0);
        chk_eq("ar_pos",   pos1, 0);
        chk_eq("ar_drop",  drop1, 0);
        #2;
        rst = 1'b1;

        // sell at zero position, then buy+sell together
        drive(1, 0, 1, 3, 7);
        step;
        chk_eq("t4_sell0_drop",  drop1, 1);
        chk_eq("t4_sell0_count", cnt1, 0);
        drive(1, 1, 1, 0, 9);
        step;
        chk_eq("t4_both_drop",  drop1, 2);
        chk_eq("t4_both_count", cnt1, 0);
        chk_eq("t4_both_pos",   pos1, 0);
        drive(0, 1, 0, 0, 9);
        step;
        chk_eq("t4_dis_drop",  drop1, 2);
        chk_eq("t4_dis_count", cnt1, 0);
        chk_eq("t4_dis_pos",   pos1, 0);
        ready = 1'b1;
        drive(1, 0, 0, 0, 9);
        step;
        chk_eq("t4_idle_count", cnt1, 0);
        chk_eq("t4_idle_drop",  drop1, 2);
        ready = 1'b0;
        drive(1, 1, 0, 0, 55);
        step;
        drive(0, 0, 0, 0, 0);
        chk_eq("t4_buy_valid", u_if1.order_valid, 1);
        chk_eq("t4_buy_data",  u_if1.order_data, ordw(1, 0, 1, 55));

        // MAX_POS=2 build: third buy is dropped
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 10 + i);
            step;
        end
        chk_eq("t5_cnt2",  cnt2, 2);
        chk_eq("t5_pos2",  pos2, pk(2, 0, 0, 0));
        chk_eq("t5_drop2", drop2, 1);
        chk_eq("t5_head2", u_if2.order_data, ordw(1, 0, 1, 10));
        chk_eq("t5_cnt1",  cnt1, 3);
        chk_eq("t5_pos1",  pos1, pk(3, 0, 0, 0));
        chk_eq("t5_drop1", drop1, 0);

        // drop counter saturation
        drive(1, 0, 1, 3, 0);
        repeat (254) step;
        chk_eq("sat_drop1_254", drop1, 254);
        chk_eq("sat_drop2_255", drop2, 255);
        step;
        chk_eq("sat_drop1_255", drop1, 255);
        repeat (5) step;
        drive(0, 0, 0, 0, 0);
        chk_eq("sat_drop1_hold", drop1, 255);
        chk_eq("sat_drop2_hold", drop2, 255);
        chk_eq("sat_cnt1", cnt1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/order_manager.md
ORDER_MANAGER -- requirements
Module: order_manager

Interface
REQ-001 Parameter MAX_POS, default 16: maximum lots held per stock, legal range 1..127.
REQ-002 Parameter FIFO_DEPTH, default 4: order queue depth, power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-005 enable  input  1  qualifies sig inputs; when 0, buy/sell ignored, drain continues.
REQ-006 buy_signal  input  1  registered buy request from momentum stage.
REQ-007 sell_signal  input  1  registered sell request from momentum stage.
REQ-008 stock_id  input  2  stock index for the current signal.
REQ-009 price  input  14  unsigned price aligned with the signal cycle.
REQ-010 order_valid  output  1  FIFO head holds a valid order.
REQ-011 order_ready  input  1  downstream accepts head when order_valid=1.
REQ-012 order_data  output  24  head order: [23] side (1=buy), [22:21] stock_id, [20:14] qty, [13:0] price.
REQ-013 fifo_count  output  5  number of queued orders, 0..FIFO_DEPTH.
REQ-014 drop_count  output  8  rejected-request counter, saturating.
REQ-015 position  output  28  per-stock lots, stock n at [7n+6:7n].

Function
REQ-016 A request is a cycle with enable=1 and exactly one of buy_signal/sell_signal = 1.
REQ-017 Buy accepted iff position[stock_id] < MAX_POS and fifo_count < FIFO_DEPTH (start-of-cycle values); enqueues side=1, qty=1, price; position[stock_id] increments same edge.
REQ-018 Sell accepted iff position[stock_id] > 0 and fifo_count < FIFO_DEPTH; enqueues side=0, qty=position[stock_id], price; position[stock_id] clears same edge.
REQ-019 Rejected request (buy at MAX_POS, sell at 0 position, FIFO full) SHALL leave positions and FIFO unchanged and increment drop_count.
REQ-020 enable=1 with buy_signal=sell_signal=1 SHALL be rejected and increment drop_count.
REQ-021 enable=0, or both signals 0, SHALL cause no enqueue and no count change.
REQ-022 drop_count SHALL saturate at 255, never wrap.
REQ-023 Dequeue occurs on edge with order_valid=1 and order_ready=1; head advances, fifo_count decrements.
REQ-024 Simultaneous enqueue and dequeue: fifo_count unchanged, both operations performed.
REQ-025 FIFO full blocks enqueue even if a dequeue occurs the same cycle (full judged on start-of-cycle count).
REQ-026 Latency: accepted request visible on order_valid/order_data the next cycle when FIFO was empty; strict FIFO order otherwise.
REQ-027 order_valid = (fifo_count != 0); order_data stable while order_valid=1 and order_ready=0.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 order_ready while order_valid=0 SHALL have no effect.

Reset
REQ-030 rst=0 SHALL asynchronously clear order_valid, fifo_count, drop_count, all positions, and both pointers.
REQ-031 Reset mid-operation SHALL discard queued orders; FIFO storage contents need not be cleared.
REQ-032 First request is evaluated on the first rising edge after rst returns to 1.

Structure
REQ-033 Shared package holds order field offsets/widths, SIDE_BUY/SIDE_SELL constants, and the stock-count constant (4).
REQ-034 Queue SHALL be a separate sub-module order_fifo (parameterised width/depth, valid/ready read side, full/count outputs).
REQ-035 Position table and accept/reject logic reside in order_manager top.

Verification
REQ-036 Reset, then buy stock 2 at price 1000 -> next cycle order_valid=1, order_data={1,2,1,1000}, position[2]=1.
REQ-037 Three buys stock 1 then sell stock 1 at 1500, order_ready=1 -> sell order qty=3 price 1500, position[1]=0.
REQ-038 order_ready=0, five buys on stocks 0..3,0 -> fifo_count=4, fifth dropped, drop_count=1.
REQ-039 Sell on stock 3 with position 0, then buy+sell same cycle -> no enqueue, drop_count=2.
REQ-040 MAX_POS=2: three buys stock 0 -> two orders, position[0]=2, drop_count=1.
REQ-041 FIFO holding 2 orders, assert rst=0 asynchronously mid-cycle -> order_valid=0, fifo_count=0, positions 0 immediately.
